cpu_bus_sched: RTL and testbench
================================

// Module: cpu_bus_sched
// PURPOSE
//  Shares the CPU's single external bus-master port between the IF-stage and MEM-stage bus interfaces.
//  Requests the system bus from the system arbiter, grants one stage at a time and muxes its address and write data onto the bus.
//  Routes ready back to the owning stage only.
//  MEM has priority; a starvation counter guarantees IF forward progress.
// PARAMETERS
//  ADDR_W        30  word-address width
//  DATA_W        32  word-data width
//  STARVE_LIMIT  4   MEM arbitration wins allowed over a waiting IF before IF is forced; legal range 1..15
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous reset, active-high
//  if_req_      in   1       IF bus request, active-low
//  if_addr      in   ADDR_W  IF address
//  if_as_       in   1       IF address strobe, active-low
//  if_rw        in   1       IF read(1)/write(0)
//  if_wr_data   in   DATA_W  IF write data
//  if_grnt_     out  1       IF grant, active-low
//  if_rdy_      out  1       IF ready: bus_rdy_ | if_grnt_
//  mem_req_     in   1       MEM bus request, active-low
//  mem_addr     in   ADDR_W  MEM address
//  mem_as_      in   1       MEM address strobe, active-low
//  mem_rw       in   1       MEM read(1)/write(0)
//  mem_wr_data  in   DATA_W  MEM write data
//  mem_grnt_    out  1       MEM grant, active-low
//  mem_rdy_     out  1       MEM ready: bus_rdy_ | mem_grnt_
//  cpu_rd_data  out  DATA_W  bus_rd_data broadcast to both stages (combinational)
//  bus_req_     out  1       request to system arbiter, active-low
//  bus_grnt_    in   1       grant from system arbiter, active-low
//  bus_addr     out  ADDR_W  muxed address
//  bus_as_      out  1       muxed strobe; 1 when no owner
//  bus_rw       out  1       muxed read/write; 1 when no owner
//  bus_wr_data  out  DATA_W  muxed write data
//  bus_rd_data  in   DATA_W  bus read data
//  bus_rdy_     in   1       bus ready, active-low
// BEHAVIOUR
//  - Reset (synchronous, active-high): state=IDLE, starve_cnt=0, if_grnt_=1, mem_grnt_=1, bus_req_=1.
//    Bus-side outputs are combinational from the registered owner, so they follow immediately: bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0.
//  - States:
//    - IDLE: any req_ low -> WAIT, bus_req_=0 on the next cycle.
//    - WAIT: bus_req_ held 0. On bus_grnt_==0, pick a winner, registered, so its grant goes low 1 cycle later -> OWN_IF / OWN_MEM. If all requests withdrawn -> IDLE, bus_req_=1.
//    - OWN_x: hold while x_req_==0. On x_req_==1, pick again if the other stage is requesting (stay owner of the bus, no re-request) -> OWN_y, else -> IDLE with bus_req_=1.
//  - Winner rule: MEM wins unless if_req_==0 and starve_cnt==STARVE_LIMIT; IF wins if it is the only requester.
//  - starve_cnt: +1 at each MEM win while if_req_==0; saturates at STARVE_LIMIT; cleared on every IF win.
//  - Ownership handover inserts 1 idle cycle: both grants=1, bus_as_=1.
//  - bus_grnt_ rising to 1 while in OWN_x: grant dropped next cycle -> WAIT; requests retained.
//  - No owner: address/data muxes output 0.
//  - Reset mid-transfer: all grants and requests released next edge; no partial-access recovery.
// CONFIGURATION
//  CPU_BUS_SCHED_STAT_EN defined:
//    - adds outputs stat_if_wait[15:0] (cycles if_req_==0 without grant) and stat_mem_wait[15:0] (same for MEM).
//    - both are saturating counters, cleared by reset.
//  Undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package/header: state encodings (SCHED_IDLE/WAIT/OWN_IF/OWN_MEM, 2 bits) and the READ/WRITE constants.
//  Single module, no sub-modules; the datapath muxes are inline assigns.
// TESTING
//  - Reset with both requests low: one cycle after reset is released -> bus_req_=0, both grants still 1 until bus_grnt_=0.
//  - IF-only: if_req_=0, bus_grnt_=0 -> if_grnt_=0 after 1 cycle; bus_addr=if_addr; if_rdy_ follows bus_rdy_, mem_rdy_=1.
//  - Simultaneous requests, STARVE_LIMIT=4: MEM gets 4 consecutive grants, the 5th goes to IF; starve_cnt then reads 0.
//  - Handover: MEM releases while IF waits -> one cycle with both grants=1, then if_grnt_=0; bus_req_ stays 0 throughout.
//  - bus_grnt_ pulled to 1 mid-OWN_MEM -> mem_grnt_=1 next cycle; bus_req_ stays 0; regrant on bus_grnt_=0.
//  - STAT_EN: IF blocked for 7 cycles -> stat_if_wait=7; reset mid-count -> 0.

Source files
------------

// File: rtl/cpu_bus_sched_pkg.sv
// Shared scheduler state encoding and bus direction constants for cpu_bus_sched.
package cpu_bus_sched_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE    = 2'd0,
        SCHED_WAIT    = 2'd1,
        SCHED_OWN_IF  = 2'd2,
        SCHED_OWN_MEM = 2'd3
    } sched_state_e;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

endpackage

// File: rtl/cpu_bus_sched.sv
// Arbitrates the CPU's single bus-master port between the IF and MEM stages (MEM priority, IF starvation guard).
// Optional wait-cycle statistics outputs are enabled by defining CPU_BUS_SCHED_STAT_EN.
module cpu_bus_sched
    import cpu_bus_sched_pkg::*;
#(
    parameter int unsigned ADDR_W       = 30,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef CPU_BUS_SCHED_STAT_EN
    output logic [15:0]       stat_if_wait,
    output logic [15:0]       stat_mem_wait,
`endif
    input  logic              if_req_,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_as_,
    input  logic              if_rw,
    input  logic [DATA_W-1:0] if_wr_data,
    output logic              if_grnt_,
    output logic              if_rdy_,
    input  logic              mem_req_,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_as_,
    input  logic              mem_rw,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_grnt_,
    output logic              mem_rdy_,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    sched_state_e state_q, state_d;
    logic [3:0]   starve_q, starve_d;
    logic         if_grnt_q, if_grnt_d;
    logic         mem_grnt_q, mem_grnt_d;
    logic         bus_req_q, bus_req_d;
    logic         if_rq, mem_rq, win_mem, pick;

    assign if_rq   = ~if_req_;
    assign mem_rq  = ~mem_req_;
    assign win_mem = mem_rq && !(if_rq && (starve_q == LIMIT));

    always_comb begin
        state_d = state_q;
        pick    = 1'b0;
        unique case (state_q)
            SCHED_IDLE: begin
                if (if_rq || mem_rq) state_d = SCHED_WAIT;
            end
            SCHED_WAIT: begin
                if (!(if_rq || mem_rq)) begin
                    state_d = SCHED_IDLE;
                end else if (!bus_grnt_) begin
                    pick    = 1'b1;
                    state_d = win_mem ? SCHED_OWN_MEM : SCHED_OWN_IF;
                end
            end
            SCHED_OWN_IF, SCHED_OWN_MEM: begin
                // Owner released: hand the bus straight to the other stage if it waits, keeping bus_req_ low.
                if ((state_q == SCHED_OWN_IF) ? !if_rq : !mem_rq) begin
                    if ((state_q == SCHED_OWN_IF) ? !mem_rq : !if_rq) begin
                        state_d = SCHED_IDLE;
                    end else if (bus_grnt_) begin
                        state_d = SCHED_WAIT;
                    end else begin
                        pick    = 1'b1;
                        state_d = win_mem ? SCHED_OWN_MEM : SCHED_OWN_IF;
                    end
                end else if (bus_grnt_) begin
                    state_d = SCHED_WAIT;
                end
            end
        endcase

        starve_d = starve_q;
        if (pick) begin
            if (!win_mem)                           starve_d = '0;
            else if (if_rq && (starve_q != LIMIT)) starve_d = starve_q + 4'd1;
        end

        // A grant is issued only when ownership is entered from WAIT or held; a handover leaves one gap cycle.
        if_grnt_d  = !((state_d == SCHED_OWN_IF) &&
                       (state_q == SCHED_OWN_IF || state_q == SCHED_WAIT));
        mem_grnt_d = !((state_d == SCHED_OWN_MEM) &&
                       (state_q == SCHED_OWN_MEM || state_q == SCHED_WAIT));
        bus_req_d  = (state_d == SCHED_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SCHED_IDLE;
            starve_q   <= '0;
            if_grnt_q  <= 1'b1;
            mem_grnt_q <= 1'b1;
            bus_req_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            if_grnt_q  <= if_grnt_d;
            mem_grnt_q <= mem_grnt_d;
            bus_req_q  <= bus_req_d;
        end
    end

    assign if_grnt_    = if_grnt_q;
    assign mem_grnt_   = mem_grnt_q;
    assign bus_req_    = bus_req_q;
    assign if_rdy_     = bus_rdy_ | if_grnt_q;
    assign mem_rdy_    = bus_rdy_ | mem_grnt_q;
    assign cpu_rd_data = bus_rd_data;

    assign bus_addr    = !if_grnt_q ? if_addr    : !mem_grnt_q ? mem_addr    : '0;
    assign bus_wr_data = !if_grnt_q ? if_wr_data : !mem_grnt_q ? mem_wr_data : '0;
    assign bus_as_     = !if_grnt_q ? if_as_     : !mem_grnt_q ? mem_as_     : 1'b1;
    assign bus_rw      = !if_grnt_q ? if_rw      : !mem_grnt_q ? mem_rw      : READ;

`ifdef CPU_BUS_SCHED_STAT_EN
    logic [15:0] stat_if_q, stat_mem_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_if_q  <= '0;
            stat_mem_q <= '0;
        end else begin
            if (if_rq && if_grnt_q && (stat_if_q != '1))    stat_if_q  <= stat_if_q + 16'd1;
            if (mem_rq && mem_grnt_q && (stat_mem_q != '1)) stat_mem_q <= stat_mem_q + 16'd1;
        end
    end

    assign stat_if_wait  = stat_if_q;
    assign stat_mem_wait = stat_mem_q;
`endif

endmodule

// File: tb/tb_cpu_bus_sched.sv
// Self-checking bench for cpu_bus_sched: directed scenarios plus randomized traffic against an ownership-level model.
module tb_cpu_bus_sched;

    localparam int unsigned AW  = 30;
    localparam int unsigned DW  = 32;
    localparam int          LIM = 4;
    localparam int NONE = 0, IFS = 1, MEMS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req_ = 1'b1, if_as_ = 1'b1, if_rw = 1'b1;
    logic          mem_req_ = 1'b1, mem_as_ = 1'b1, mem_rw = 1'b1;
    logic [AW-1:0] if_addr = '0, mem_addr = '0, bus_addr;
    logic [DW-1:0] if_wr_data = '0, mem_wr_data = '0, bus_wr_data, bus_rd_data = '0, cpu_rd_data;
    logic          if_grnt_, if_rdy_, mem_grnt_, mem_rdy_;
    logic          bus_req_, bus_grnt_ = 1'b1, bus_as_, bus_rw, bus_rdy_ = 1'b1;
`ifdef CPU_BUS_SCHED_STAT_EN
    logic [15:0]   stat_if_wait, stat_mem_wait;
`endif

    int checks = 0;
    int failures = 0;

    // Model: bus held or not, granted owner, owner chosen but still in its gap cycle, starvation count.
    bit m_busreq = 1'b0;
    int m_owner  = NONE;
    int m_pend   = NONE;
    int m_cnt    = 0;

    always #5 clk = ~clk;

    cpu_bus_sched #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
`ifdef CPU_BUS_SCHED_STAT_EN
        .stat_if_wait(stat_if_wait), .stat_mem_wait(stat_mem_wait),
`endif
        .if_req_(if_req_), .if_addr(if_addr), .if_as_(if_as_), .if_rw(if_rw),
        .if_wr_data(if_wr_data), .if_grnt_(if_grnt_), .if_rdy_(if_rdy_),
        .mem_req_(mem_req_), .mem_addr(mem_addr), .mem_as_(mem_as_), .mem_rw(mem_rw),
        .mem_wr_data(mem_wr_data), .mem_grnt_(mem_grnt_), .mem_rdy_(mem_rdy_),
        .cpu_rd_data(cpu_rd_data), .bus_req_(bus_req_), .bus_grnt_(bus_grnt_),
        .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
    );

    function automatic int pick_winner(bit ir, bit mr);
        if (mr && !(ir && m_cnt == LIM)) begin
            if (ir && m_cnt < LIM) m_cnt = m_cnt + 1;
            return MEMS;
        end
        m_cnt = 0;
        return IFS;
    endfunction

    task automatic model_step();
        bit ir, mr, g, xr, other;
        int cur;
        ir = !if_req_; mr = !mem_req_; g = !bus_grnt_;
        if (reset) begin
            m_busreq = 1'b0; m_owner = NONE; m_pend = NONE; m_cnt = 0;
        end else if (!m_busreq) begin
            if (ir || mr) m_busreq = 1'b1;
        end else if (m_owner == NONE && m_pend == NONE) begin
            if (!(ir || mr)) m_busreq = 1'b0;
            else if (g) m_owner = pick_winner(ir, mr);
        end else begin
            cur   = (m_owner != NONE) ? m_owner : m_pend;
            xr    = (cur == IFS) ? ir : mr;
            other = (cur == IFS) ? mr : ir;
            m_owner = NONE; m_pend = NONE;
            if (!xr) begin
                if (!other) m_busreq = 1'b0;
                else if (g) m_pend = pick_winner(ir, mr);
            end else if (g) begin
                m_owner = cur;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; if_req_ = 1'b1; mem_req_ = 1'b1; bus_grnt_ = 1'b1;
        cycle(); cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req_ = 1'b0; mem_req_ = 1'b0; bus_grnt_ = 1'b1;
        cycle(); cycle();
        checks++;
        if ({if_grnt_, mem_grnt_, bus_req_, bus_as_, bus_rw} !== 5'b11111) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=11111", {if_grnt_, mem_grnt_, bus_req_, bus_as_, bus_rw});
        end
        checks++;
        if (bus_addr !== '0 || bus_wr_data !== '0) begin
            failures++;
            $display("FAIL reset_data addr=%h wdata=%h exp=0", bus_addr, bus_wr_data);
        end
        reset = 1'b0;
        cycle();
        checks++;
        if ({bus_req_, if_grnt_, mem_grnt_} !== 3'b011) begin
            failures++;
            $display("FAIL reset_release got=%b exp=011", {bus_req_, if_grnt_, mem_grnt_});
        end
    endtask

    task automatic test_if_only();
        do_reset();
        if_req_ = 1'b0; if_addr = AW'($urandom); if_wr_data = $urandom;
        if_as_ = 1'b0; if_rw = 1'b0; bus_grnt_ = 1'b0; bus_rd_data = $urandom;
        cycle();
        checks++;
        if ({bus_req_, if_grnt_} !== 2'b01) begin
            failures++;
            $display("FAIL if_only_wait got=%b exp=01", {bus_req_, if_grnt_});
        end
        cycle();
        checks++;
        if ({if_grnt_, mem_grnt_, bus_as_, bus_rw} !== 4'b0100) begin
            failures++;
            $display("FAIL if_only_grant got=%b exp=0100", {if_grnt_, mem_grnt_, bus_as_, bus_rw});
        end
        checks++;
        if (bus_addr !== if_addr || bus_wr_data !== if_wr_data || cpu_rd_data !== bus_rd_data) begin
            failures++;
            $display("FAIL if_only_mux addr=%h/%h wdata=%h/%h rdata=%h/%h", bus_addr, if_addr,
                     bus_wr_data, if_wr_data, cpu_rd_data, bus_rd_data);
        end
        bus_rdy_ = 1'b0; #1;
        checks++;
        if ({if_rdy_, mem_rdy_} !== 2'b01) begin
            failures++;
            $display("FAIL if_only_rdy_low got=%b exp=01", {if_rdy_, mem_rdy_});
        end
        bus_rdy_ = 1'b1; #1;
        checks++;
        if ({if_rdy_, mem_rdy_} !== 2'b11) begin
            failures++;
            $display("FAIL if_only_rdy_high got=%b exp=11", {if_rdy_, mem_rdy_});
        end
    endtask

    task automatic test_starve();
        logic [1:0] exp;
        do_reset();
        if_req_ = 1'b0; mem_req_ = 1'b0; bus_grnt_ = 1'b0;
        cycle();
        for (int i = 0; i < 6; i++) begin
            cycle();
            exp = (i == LIM) ? 2'b01 : 2'b10;
            checks++;
            if ({if_grnt_, mem_grnt_} !== exp) begin
                failures++;
                $display("FAIL starve_win%0d got=%b exp=%b", i, {if_grnt_, mem_grnt_}, exp);
            end
            bus_grnt_ = 1'b1;
            cycle();
            checks++;
            if ({if_grnt_, mem_grnt_, bus_req_} !== 3'b110) begin
                failures++;
                $display("FAIL starve_drop%0d got=%b exp=110", i, {if_grnt_, mem_grnt_, bus_req_});
            end
            bus_grnt_ = 1'b0;
        end
    endtask

    task automatic test_handover();
        do_reset();
        if_req_ = 1'b0; mem_req_ = 1'b0; bus_grnt_ = 1'b0;
        cycle(); cycle();
        checks++;
        if ({if_grnt_, mem_grnt_} !== 2'b10) begin
            failures++;
            $display("FAIL handover_mem got=%b exp=10", {if_grnt_, mem_grnt_});
        end
        mem_req_ = 1'b1;
        cycle();
        checks++;
        if ({if_grnt_, mem_grnt_, bus_as_, bus_req_} !== 4'b1110) begin
            failures++;
            $display("FAIL handover_gap got=%b exp=1110", {if_grnt_, mem_grnt_, bus_as_, bus_req_});
        end
        cycle();
        checks++;
        if ({if_grnt_, mem_grnt_, bus_req_} !== 3'b010) begin
            failures++;
            $display("FAIL handover_if got=%b exp=010", {if_grnt_, mem_grnt_, bus_req_});
        end
    endtask

    task automatic test_grant_loss();
        do_reset();
        mem_req_ = 1'b0; bus_grnt_ = 1'b0;
        cycle(); cycle();
        bus_grnt_ = 1'b1;
        cycle();
        checks++;
        if ({mem_grnt_, bus_req_} !== 2'b10) begin
            failures++;
            $display("FAIL loss_drop got=%b exp=10", {mem_grnt_, bus_req_});
        end
        cycle();
        checks++;
        if ({mem_grnt_, bus_req_} !== 2'b10) begin
            failures++;
            $display("FAIL loss_hold got=%b exp=10", {mem_grnt_, bus_req_});
        end
        bus_grnt_ = 1'b0;
        cycle();
        checks++;
        if ({mem_grnt_, bus_req_} !== 2'b00) begin
            failures++;
            $display("FAIL loss_regrant got=%b exp=00", {mem_grnt_, bus_req_});
        end
    endtask

`ifdef CPU_BUS_SCHED_STAT_EN
    task automatic test_stat();
        do_reset();
        if_req_ = 1'b0; bus_grnt_ = 1'b1;
        repeat (7) cycle();
        checks++;
        if (stat_if_wait !== 16'd7 || stat_mem_wait !== 16'd0) begin
            failures++;
            $display("FAIL stat_count if=%0d mem=%0d exp=7/0", stat_if_wait, stat_mem_wait);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if (stat_if_wait !== 16'd0) begin
            failures++;
            $display("FAIL stat_reset got=%0d exp=0", stat_if_wait);
        end
    endtask
`endif

    task automatic test_random();
        logic [6:0]    exp_ctl;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) if_req_ = ~if_req_;
            if ($urandom_range(0, 3) == 0) mem_req_ = ~mem_req_;
            bus_grnt_ = ($urandom_range(0, 5) == 0);
            cycle();
            bus_rdy_ = 1'($urandom); if_as_ = 1'($urandom); mem_as_ = 1'($urandom);
            if_rw = 1'($urandom); mem_rw = 1'($urandom);
            if_addr = AW'($urandom); mem_addr = AW'($urandom);
            if_wr_data = $urandom; mem_wr_data = $urandom;
            #1;
            exp_ctl = {m_owner != IFS, m_owner != MEMS, !m_busreq,
                       m_owner == IFS ? if_as_ : m_owner == MEMS ? mem_as_ : 1'b1,
                       m_owner == IFS ? if_rw  : m_owner == MEMS ? mem_rw  : 1'b1,
                       bus_rdy_ | (m_owner != IFS), bus_rdy_ | (m_owner != MEMS)};
            exp_addr = m_owner == IFS ? if_addr : m_owner == MEMS ? mem_addr : '0;
            exp_wd   = m_owner == IFS ? if_wr_data : m_owner == MEMS ? mem_wr_data : '0;
            checks++;
            if ({if_grnt_, mem_grnt_, bus_req_, bus_as_, bus_rw, if_rdy_, mem_rdy_} !== exp_ctl) begin
                failures++;
                $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", c,
                         {if_grnt_, mem_grnt_, bus_req_, bus_as_, bus_rw, if_rdy_, mem_rdy_}, exp_ctl);
            end
            checks++;
            if (bus_addr !== exp_addr || bus_wr_data !== exp_wd) begin
                failures++;
                $display("FAIL rand_data cyc=%0d addr=%h exp=%h wdata=%h exp=%h", c,
                         bus_addr, exp_addr, bus_wr_data, exp_wd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_starve();
        test_handover();
        test_grant_loss();
`ifdef CPU_BUS_SCHED_STAT_EN
        test_stat();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
